dac_smooth_tx: RTL and testbench
================================

Name: dac_smooth_tx

Overview:
- Transmit-side counterpart of the ADC receive filter chain. Accepts processed samples from an AXI-Stream source and holds each one for 2^HOLD_LOG2 clocks (zero-order-hold upsampling).
- Smooths the held staircase with the same first-order Q32 IIR low-pass used on the ADC path: y = B·(x + x1) + y1 − 2B·(y1>>>32).
- Drives the DAC data bus every clock and reports source underflow.

Parameters:
- DAC_WIDTH, 14, DAC sample width (signed, two's complement internally).
- AXIS_TDATA_WIDTH, 32, input stream width; sample taken from bits [DAC_WIDTH-1:0].
- B, 2158, Q32 filter coefficient; pole = 1 − 2B/2^32.
- HOLD_LOG2, 3, log2 of clocks per input sample (1..8).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  input sample.
- s_axis_tvalid  in  1  source valid.
- s_axis_tready  out  1  block ready.
- dac_dat_a  out  DAC_WIDTH  filtered DAC code.
- sample_tick  out  1  one-clock pulse when a beat is accepted.
- underflow  out  1  sticky: a hold period expired with no data.
- underflow_clr  in  1  clears underflow and underflow_cnt.
- underflow_cnt  out  16  missed-sample count, saturates at 0xFFFF.

Behaviour:
- Reset (reset=0, sampled at the clk edge) sets:
  - state=IDLE; hold counter cnt=0; x_hold=0, x_hold_d=0; pipeline registers and y=0.
  - dac_dat_a=0; s_axis_tready=0; sample_tick=0; underflow=0; underflow_cnt=0.
  - Reset mid-stream discards any held sample. No beat is accepted in the reset cycle.
- Handshake: a beat transfers when s_axis_tvalid & s_axis_tready. s_axis_tready is combinational from state and cnt only, never from tvalid.
- State machine:
  - IDLE: tready=1, cnt held at 0. On transfer: load x_hold, cnt<=0, go to RUN.
  - RUN: cnt increments every clock, wrapping at 2^HOLD_LOG2−1. tready=1 only when cnt=2^HOLD_LOG2−1.
    - At the wrap with a transfer: load x_hold, stay in RUN.
    - At the wrap without tvalid: keep x_hold, go to STARVED, set underflow, increment underflow_cnt.
  - STARVED: tready=1 every clock; cnt keeps counting.
    - On transfer: load x_hold, cnt<=0, go to RUN.
    - Each further wrap without a transfer increments underflow_cnt again.
- sample_tick=1 in the clock after every transfer.
- Filter pipeline runs every clock on x_hold. Internal width DAC_WIDTH+32, signed.
  - Stage 1: p0<=B·x_hold; p1<=B·x_hold_d; x_hold_d<=x_hold.
  - Stage 2: s<=p0+p1.
  - Stage 3: y<=s + y − 2B·(y>>>32).
  - Stage 4: dac_dat_a<=sat((y + 2^31)>>>32), i.e. rounded and clamped to [−2^(DAC_WIDTH−1), 2^(DAC_WIDTH−1)−1].
- Latency: a change in x_hold at edge k first appears on dac_dat_a at edge k+4.
- DC gain is 1: steady-state dac_dat_a equals x_hold within ±1 LSB.
- Simultaneous underflow_clr and a new underflow event: underflow=1 and underflow_cnt=1 (set wins).
- underflow_cnt does not wrap.

Optional Feature:
- DAC_OFFSET_BINARY_EN.
- Defined: dac_dat_a is output in offset binary (MSB inverted after saturation); reset value is 2^(DAC_WIDTH−1) (0x2000 for 14 bits).
- Undefined: two's complement output; reset value 0.
- Internal arithmetic is identical in both cases.

Test Plan:
- B=2^28, HOLD_LOG2=3, tvalid held 1 with constant 1000 → tready pulses once per 8 clocks; sample_tick follows each transfer; dac_dat_a rises monotonically with no overshoot; dac_dat_a is 1000±1 within 200 clocks; underflow stays 0.
- B=2^28, step input 0→−8192 then →8191 → dac_dat_a never leaves [−8192, 8191]; settles to each endpoint ±1; first change occurs 4 clocks after the load.
- Source stops after 3 beats of 500 → STARVED entered at the next wrap; underflow=1; underflow_cnt increments every 8 clocks; dac_dat_a holds 500±1. Resume tvalid → beat accepted the same clock, state returns to RUN.
- underflow_clr asserted on the same clock as a missed wrap → underflow=1, underflow_cnt=1. underflow_clr alone → both cleared.
- Reset pulsed low for 1 clock mid-stream while dac_dat_a≈1000 → the next clock shows dac_dat_a=0, tready=0, state=IDLE. With DAC_OFFSET_BINARY_EN defined, the same test expects 0x2000, and a settled input of 1000 reads 0x23E8.

Source files
------------

// File: rtl/dac_smooth_tx.sv
// Zero-order-hold upsampler for an AXI-Stream sample source, followed by a first-order Q32 IIR smoother driving a DAC bus.
// Optional DAC_OFFSET_BINARY_EN: emit offset-binary codes (MSB inverted after saturation) instead of two's complement.
module dac_smooth_tx #(
    parameter int DAC_WIDTH        = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int B                = 2158,
    parameter int HOLD_LOG2        = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [DAC_WIDTH-1:0]        dac_dat_a,
    output logic                        sample_tick,
    output logic                        underflow,
    input  logic                        underflow_clr,
    output logic [15:0]                 underflow_cnt
);

    localparam int W = DAC_WIDTH + 32;
    localparam logic signed [W-1:0] B_S     = W'(longint'(B));
    localparam logic signed [W-1:0] TWO_B_S = W'(2 * longint'(B));
    localparam logic signed [W:0]   HALF_S  = (W+1)'(64'sd2147483648);
    localparam logic [HOLD_LOG2-1:0] CNT_MAX = '1;
`ifdef DAC_OFFSET_BINARY_EN
    localparam logic [DAC_WIDTH-1:0] OUT_XOR = {1'b1, {(DAC_WIDTH-1){1'b0}}};
`else
    localparam logic [DAC_WIDTH-1:0] OUT_XOR = '0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, STARVED} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [HOLD_LOG2-1:0]   r_cnt;
    logic [HOLD_LOG2-1:0]   w_cnt_next;
    logic                   r_rst_done;
    logic                   r_tick;
    logic                   r_underflow;
    logic [15:0]            r_uf_cnt;
    logic                   w_wrap;
    logic                   w_ready;
    logic                   w_xfer;
    logic                   w_load;
    logic                   w_miss;

    logic signed [DAC_WIDTH-1:0] r_x_hold;
    logic signed [DAC_WIDTH-1:0] r_x_hold_d;
    logic signed [W-1:0]         r_p0;
    logic signed [W-1:0]         r_p1;
    logic signed [W-1:0]         r_s;
    logic signed [W-1:0]         r_y;
    logic [DAC_WIDTH-1:0]        r_dac;
    logic signed [W-1:0]         w_x_ext;
    logic signed [W-1:0]         w_xd_ext;
    logic signed [W-1:0]         w_fb;
    logic signed [W:0]           w_rnd;
    logic [DAC_WIDTH:0]          w_q;
    logic [DAC_WIDTH-1:0]        w_sat;
    logic                        w_unused_tdata;

    // Ready depends on state/count only; r_rst_done keeps it low for the clock after reset.
    assign w_wrap  = (r_cnt == CNT_MAX);
    assign w_ready = r_rst_done && ((r_state == IDLE) || (r_state == STARVED) ||
                                    ((r_state == RUN) && w_wrap));
    assign w_xfer  = s_axis_tvalid && w_ready;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + HOLD_LOG2'(1);
        w_load       = 1'b0;
        w_miss       = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (w_xfer) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_wrap) begin
                    if (w_xfer) begin
                        w_load = 1'b1;
                    end else begin
                        w_miss       = 1'b1;
                        w_state_next = STARVED;
                    end
                end
            end
            STARVED: begin
                if (w_xfer) begin
                    w_load       = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = RUN;
                end else if (w_wrap) begin
                    w_miss = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rst_done  <= 1'b0;
            r_tick      <= 1'b0;
            r_underflow <= 1'b0;
            r_uf_cnt    <= '0;
            r_x_hold    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_rst_done <= 1'b1;
            r_tick     <= w_xfer;
            if (w_load) begin
                r_x_hold <= s_axis_tdata[DAC_WIDTH-1:0];
            end
            // A missed sample outranks a simultaneous clear.
            if (w_miss) begin
                r_underflow <= 1'b1;
                if (underflow_clr) begin
                    r_uf_cnt <= 16'd1;
                end else if (r_uf_cnt != 16'hFFFF) begin
                    r_uf_cnt <= r_uf_cnt + 16'd1;
                end
            end else if (underflow_clr) begin
                r_underflow <= 1'b0;
                r_uf_cnt    <= '0;
            end
        end
    end

    assign w_x_ext  = {{32{r_x_hold[DAC_WIDTH-1]}}, r_x_hold};
    assign w_xd_ext = {{32{r_x_hold_d[DAC_WIDTH-1]}}, r_x_hold_d};
    assign w_fb     = (r_y >>> 32) * TWO_B_S;
    assign w_rnd    = $signed({r_y[W-1], r_y}) + HALF_S;
    assign w_q      = w_rnd[W:32];

    always_comb begin
        w_sat = w_q[DAC_WIDTH-1:0];
        if (w_q[DAC_WIDTH] != w_q[DAC_WIDTH-1]) begin
            w_sat = {w_q[DAC_WIDTH], {(DAC_WIDTH-1){~w_q[DAC_WIDTH]}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x_hold_d <= '0;
            r_p0       <= '0;
            r_p1       <= '0;
            r_s        <= '0;
            r_y        <= '0;
            r_dac      <= OUT_XOR;
        end else begin
            r_x_hold_d <= r_x_hold;
            r_p0       <= w_x_ext * B_S;
            r_p1       <= w_xd_ext * B_S;
            r_s        <= r_p0 + r_p1;
            r_y        <= r_s + r_y - w_fb;
            r_dac      <= w_sat ^ OUT_XOR;
        end
    end

    assign w_unused_tdata = &{1'b0, s_axis_tdata[AXIS_TDATA_WIDTH-1:DAC_WIDTH]};

    assign s_axis_tready = w_ready;
    assign dac_dat_a     = r_dac;
    assign sample_tick   = r_tick;
    assign underflow     = r_underflow;
    assign underflow_cnt = r_uf_cnt;

endmodule

// File: tb/tb_dac_smooth_tx.sv
// Scoreboard bench for dac_smooth_tx: accepted beats queue their expected sample_tick cycle, DAC values checked against step-response bounds.
module tb_dac_smooth_tx;

    localparam int DW = 14;
    localparam int HL = 3;
    localparam int BCOEF = 268435456;
`ifdef DAC_OFFSET_BINARY_EN
    localparam logic [DW-1:0] RST_CODE = 14'h2000;
`else
    localparam logic [DW-1:0] RST_CODE = 14'h0000;
`endif

    logic          clk;
    logic          reset;
    logic [31:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] dac_dat_a;
    logic          sample_tick;
    logic          underflow;
    logic          underflow_clr;
    logic [15:0]   underflow_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;
    int hs_cnt  = 0;
    bit last_hs = 0;
    int exp_q[$];
    int obs_q[$];

    dac_smooth_tx #(
        .DAC_WIDTH(DW), .AXIS_TDATA_WIDTH(32), .B(BCOEF), .HOLD_LOG2(HL)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .dac_dat_a(dac_dat_a), .sample_tick(sample_tick),
        .underflow(underflow), .underflow_clr(underflow_clr), .underflow_cnt(underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dec(input logic [DW-1:0] d);
`ifdef DAC_OFFSET_BINARY_EN
        return int'($signed(d ^ 14'h2000));
`else
        return int'($signed(d));
`endif
    endfunction

    // One clock: note whether a beat transfers at this edge, then look #1 after it.
    task automatic tick();
        bit hs;
        hs = (s_axis_tvalid === 1'b1) && (s_axis_tready === 1'b1) && (reset === 1'b1);
        @(posedge clk);
        cyc_no++;
        last_hs = hs;
        if (hs) begin
            hs_cnt++;
            exp_q.push_back(cyc_no);
        end
        #1;
        if (sample_tick === 1'b1) obs_q.push_back(cyc_no);
    endtask

    task automatic do_reset();
        reset = 1'b0; s_axis_tvalid = 1'b0; underflow_clr = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; underflow_clr = 1'b0;
        tick(); tick();
        n_tests++; if (dac_dat_a !== RST_CODE) begin n_fail++; $display("FAIL reset_dac got %h want %h", dac_dat_a, RST_CODE); end
        n_tests++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got %b want 0", s_axis_tready); end
        n_tests++; if (sample_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", sample_tick); end
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow got %b want 0", underflow); end
        n_tests++; if (underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_ufcnt got %0d want 0", underflow_cnt); end
        reset = 1'b1;
        tick();
        n_tests++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL idle_tready got %b want 1", s_axis_tready); end
        $display("[TB] test_reset done at cycle %0d", cyc_no);
    endtask

    task automatic test_stream();
        int c0, ld, first, prev, v, last_hs_cyc, gap_bad, bad_v;
        bit mono_ok;
        do_reset();
        c0 = hs_cnt; ld = -1; first = -1; prev = dec(dac_dat_a); mono_ok = 1; gap_bad = 0; last_hs_cyc = -1; bad_v = 0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'd1000;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (last_hs) begin
                if (ld < 0) ld = cyc_no;
                if (last_hs_cyc >= 0 && cyc_no - last_hs_cyc != 8) gap_bad++;
                last_hs_cyc = cyc_no;
            end
            v = dec(dac_dat_a);
            if (first < 0 && v != 0) first = cyc_no;
            if (v < prev || v > 1001) begin mono_ok = 0; bad_v = v; end
            prev = v;
        end
        n_tests++; if (hs_cnt - c0 != 25) begin n_fail++; $display("FAIL stream_beats got %0d want 25", hs_cnt - c0); end
        n_tests++; if (gap_bad != 0) begin n_fail++; $display("FAIL stream_gap got %0d bad gaps want 0", gap_bad); end
        n_tests++; if (first - ld != 4) begin n_fail++; $display("FAIL stream_latency got %0d want 4", first - ld); end
        n_tests++; if (!mono_ok) begin n_fail++; $display("FAIL stream_monotonic got value %0d want rising <=1001", bad_v); end
        n_tests++; if (prev < 999 || prev > 1001) begin n_fail++; $display("FAIL stream_settle got %0d want 1000+-1", prev); end
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL stream_underflow got %b want 0", underflow); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++; $display("FAIL stream_ticks got %0d ticks want %0d", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                int e, o;
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL stream_tick got cycle %0d want %0d", o, e); end
            end
        end
        $display("[TB] test_stream beats=%0d dac=%0d", hs_cnt - c0, prev);
    endtask

    task automatic test_step();
        int ld, first, prev, v, bad_v, hs0;
        bit ok;
        do_reset();
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'hFFFF_E000;
        ld = -1; first = -1; prev = dec(dac_dat_a); ok = 1; bad_v = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (last_hs && ld < 0) ld = cyc_no;
            v = dec(dac_dat_a);
            if (first < 0 && v != 0) first = cyc_no;
            if (v > prev || v < -8192 || v > 8191) begin ok = 0; bad_v = v; end
            prev = v;
        end
        n_tests++; if (first - ld != 4) begin n_fail++; $display("FAIL step_neg_latency got %0d want 4", first - ld); end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL step_neg_range got %0d want falling in range", bad_v); end
        n_tests++; if (prev < -8192 || prev > -8191) begin n_fail++; $display("FAIL step_neg_settle got %0d want -8192+1", prev); end
        s_axis_tdata = 32'd8191;
        hs0 = prev; ld = -1; first = -1; ok = 1;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (last_hs && ld < 0) ld = cyc_no;
            v = dec(dac_dat_a);
            if (first < 0 && v != hs0) first = cyc_no;
            if (v < prev || v < -8192 || v > 8191) begin ok = 0; bad_v = v; end
            prev = v;
        end
        n_tests++; if (first - ld != 4) begin n_fail++; $display("FAIL step_pos_latency got %0d want 4", first - ld); end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL step_pos_range got %0d want rising in range", bad_v); end
        n_tests++; if (prev < 8190 || prev > 8191) begin n_fail++; $display("FAIL step_pos_settle got %0d want 8191-1", prev); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++; $display("FAIL step_ticks got %0d ticks want %0d", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                int e, o;
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL step_tick got cycle %0d want %0d", o, e); end
            end
        end
        $display("[TB] test_step final dac=%0d", prev);
    endtask

    task automatic test_starve();
        int c0, c3, guard, exp_cnt, v, h;
        bit exp_rdy;
        do_reset();
        c0 = hs_cnt; guard = 0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'd500;
        while (hs_cnt - c0 < 3 && guard < 40) begin tick(); guard++; end
        n_tests++; if (hs_cnt - c0 != 3) begin n_fail++; $display("FAIL starve_beats got %0d want 3", hs_cnt - c0); end
        c3 = cyc_no;
        s_axis_tvalid = 1'b0;
        for (int j = 1; j <= 75; j++) begin
            tick();
            exp_cnt = (cyc_no - c3) / 8;
            exp_rdy = (cyc_no - c3) >= 7;
            n_tests++; if (underflow_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL starve_cnt cyc %0d got %0d want %0d", j, underflow_cnt, exp_cnt); end
            n_tests++; if (underflow !== (exp_cnt > 0)) begin n_fail++; $display("FAIL starve_flag cyc %0d got %b want %b", j, underflow, exp_cnt > 0); end
            n_tests++; if (s_axis_tready !== exp_rdy) begin n_fail++; $display("FAIL starve_tready cyc %0d got %b want %b", j, s_axis_tready, exp_rdy); end
        end
        v = dec(dac_dat_a);
        n_tests++; if (v < 499 || v > 501) begin n_fail++; $display("FAIL starve_hold got %0d want 500+-1", v); end
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'd500; h = hs_cnt;
        tick();
        n_tests++; if (hs_cnt != h + 1) begin n_fail++; $display("FAIL resume_accept got %0d beats want 1", hs_cnt - h); end
        n_tests++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL resume_run_tready got %b want 0", s_axis_tready); end
        n_tests++; if (underflow_cnt !== 16'd9) begin n_fail++; $display("FAIL resume_cnt got %0d want 9", underflow_cnt); end
        n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL resume_flag got %b want 1", underflow); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++; $display("FAIL starve_ticks got %0d ticks want %0d", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                int e, o;
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL starve_tick got cycle %0d want %0d", o, e); end
            end
        end
        $display("[TB] test_starve underflow_cnt=%0d", underflow_cnt);
    endtask

    // Runs straight after test_starve: state RUN with the hold counter at 0.
    task automatic test_clear();
        s_axis_tvalid = 1'b0;
        repeat (7) tick();
        n_tests++; if (underflow_cnt !== 16'd9) begin n_fail++; $display("FAIL clear_pre got %0d want 9", underflow_cnt); end
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL clear_setwins_flag got %b want 1", underflow); end
        n_tests++; if (underflow_cnt !== 16'd1) begin n_fail++; $display("FAIL clear_setwins_cnt got %0d want 1", underflow_cnt); end
        tick(); tick();
        n_tests++; if (underflow_cnt !== 16'd1) begin n_fail++; $display("FAIL clear_hold got %0d want 1", underflow_cnt); end
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL clear_only_flag got %b want 0", underflow); end
        n_tests++; if (underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL clear_only_cnt got %0d want 0", underflow_cnt); end
        exp_q.delete(); obs_q.delete();
        $display("[TB] test_clear done at cycle %0d", cyc_no);
    endtask

    task automatic test_reset_mid();
        int v;
        do_reset();
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'd1000;
        repeat (100) tick();
        v = dec(dac_dat_a);
        n_tests++; if (v < 999 || v > 1001) begin n_fail++; $display("FAIL mid_settle got %0d want 1000+-1", v); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_tests++; if (dac_dat_a !== RST_CODE) begin n_fail++; $display("FAIL mid_reset_dac got %h want %h", dac_dat_a, RST_CODE); end
        n_tests++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_tready got %b want 0", s_axis_tready); end
        n_tests++; if (sample_tick !== 1'b0) begin n_fail++; $display("FAIL mid_reset_tick got %b want 0", sample_tick); end
        s_axis_tvalid = 1'b0;
        tick();
        n_tests++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL mid_idle_tready got %b want 1", s_axis_tready); end
        repeat (10) tick();
        n_tests++; if (dac_dat_a !== RST_CODE) begin n_fail++; $display("FAIL mid_discard got %h want %h", dac_dat_a, RST_CODE); end
        n_tests++; if (underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_ufcnt got %0d want 0", underflow_cnt); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++; $display("FAIL mid_ticks got %0d ticks want %0d", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                int e, o;
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL mid_tick got cycle %0d want %0d", o, e); end
            end
        end
        $display("[TB] test_reset_mid done at cycle %0d", cyc_no);
    endtask

    initial begin
        reset = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; underflow_clr = 1'b0;
        test_reset();
        test_stream();
        test_step();
        test_starve();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
